// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC owner, four-phase icache requester and one-entry decode slot
// Optional FETCH_PERF_COUNTERS_EN adds perf_fetched / perf_decode_stall outputs.
module instruction_fetch_stage #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INSN_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  icache_read_enable,
    output logic [ADDR_WIDTH-1:0] icache_address,
    input  logic [INSN_WIDTH-1:0] icache_data,
    input  logic                  icache_send_enable,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  decode_valid,
    input  logic                  decode_ready,
    output logic [INSN_WIDTH-1:0] decode_insn,
    output logic [ADDR_WIDTH-1:0] decode_pc
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [63:0]           perf_fetched,
    output logic [63:0]           perf_decode_stall
`endif
);

    typedef enum logic [1:0] {
        REQUEST   = 2'd0,
        RELEASE   = 2'd1,
        WAIT_SLOT = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   req_pc_q;
    logic                    drop_pending_q;
    logic                    decode_valid_q;
    logic [INSN_WIDTH-1:0]   decode_insn_q;
    logic [ADDR_WIDTH-1:0]   decode_pc_q;

    logic [ADDR_WIDTH-1:0]   redirect_pc_d;
    logic [ADDR_WIDTH-1:0]   pc_plus4_d;
    logic                    handshake_d;
    logic                    slot_free_d;

    assign redirect_pc_d = redirect_pc & ALIGN_MASK;
    assign pc_plus4_d    = pc_q + ADDR_WIDTH'(4);
    // A redirect flushes the slot, so a handshake in that cycle does not count.
    assign handshake_d   = decode_valid_q && decode_ready && !redirect_valid;
    assign slot_free_d   = !decode_valid_q || decode_ready || redirect_valid;

    assign icache_read_enable = (state_q == REQUEST);
    assign icache_address     = (state_q == REQUEST) ? req_pc_q : pc_q;
    assign decode_valid       = decode_valid_q;
    assign decode_insn        = decode_insn_q;
    assign decode_pc          = decode_pc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= RELEASE;
            pc_q           <= RESET_PC_AL;
            req_pc_q       <= RESET_PC_AL;
            drop_pending_q <= 1'b0;
            decode_valid_q <= 1'b0;
            decode_insn_q  <= '0;
            decode_pc_q    <= '0;
        end else begin
            if (handshake_d) begin
                decode_valid_q <= 1'b0;
            end

            case (state_q)
                REQUEST: begin
                    if (icache_send_enable) begin
                        state_q        <= RELEASE;
                        drop_pending_q <= 1'b0;
                        if (!drop_pending_q && !redirect_valid) begin
                            decode_insn_q  <= icache_data;
                            decode_pc_q    <= pc_q;
                            decode_valid_q <= 1'b1;
                            pc_q           <= pc_plus4_d;
                        end
                    end else if (redirect_valid) begin
                        // The cache may be mid-miss; let the response land and drop it.
                        drop_pending_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!icache_send_enable) begin
                        state_q <= slot_free_d ? REQUEST : WAIT_SLOT;
                    end
                end
                WAIT_SLOT: begin
                    if (decode_ready || redirect_valid) begin
                        state_q <= REQUEST;
                    end
                end
                default: begin
                    state_q <= RELEASE;
                end
            endcase

            if (state_q != REQUEST) begin
                req_pc_q <= redirect_valid ? redirect_pc_d : pc_q;
            end

            if (redirect_valid) begin
                pc_q           <= redirect_pc_d;
                decode_valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [63:0] perf_fetched_q;
    logic [63:0] perf_decode_stall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched_q      <= '0;
            perf_decode_stall_q <= '0;
        end else begin
            if (handshake_d) begin
                perf_fetched_q <= perf_fetched_q + 64'd1;
            end
            if (decode_valid_q && !decode_ready) begin
                perf_decode_stall_q <= perf_decode_stall_q + 64'd1;
            end
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_decode_stall = perf_decode_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench with a four-phase icache model
module tb_instruction_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        icache_read_enable;
    logic [63:0] icache_address;
    logic [31:0] icache_data;
    logic        icache_send_enable;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        decode_valid;
    logic        decode_ready;
    logic [31:0] decode_insn;
    logic [63:0] decode_pc;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_decode_stall;
`endif

    int          total = 0;
    int          bad = 0;
    int          lat = 0;
    int          viol = 0;
    int          hs_cnt = 0;
    int          st_cnt = 0;
    logic [63:0] sb[$];
    logic [63:0] mon_exp;

    always #5 clock = ~clock;

    instruction_fetch_stage #(.RESET_PC(64'h1000)) dut (
        .clock              (clock),
        .reset              (reset),
        .icache_read_enable (icache_read_enable),
        .icache_address     (icache_address),
        .icache_data        (icache_data),
        .icache_send_enable (icache_send_enable),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .decode_valid       (decode_valid),
        .decode_ready       (decode_ready),
        .decode_insn        (decode_insn),
        .decode_pc          (decode_pc)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetched       (perf_fetched),
        .perf_decode_stall  (perf_decode_stall)
`endif
    );

    function automatic logic [31:0] insn_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5EED_0000 ^ {a[63:48], 16'h0};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_COUNTERS_EN
        check("perf_fetched", perf_fetched, 64'(hs_cnt));
        check("perf_decode_stall", perf_decode_stall, 64'(st_cnt));
`endif
    endtask

    task automatic do_redirect(input logic [63:0] a);
        redirect_pc    = a;
        redirect_valid = 1'b1;
        @(posedge clock);
        #2;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("drain", 64'(sb.size()), 0);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(posedge clock);
            #3;
            n++;
        end while (!decode_valid && n < 200);
        check("valid_wait", 64'(decode_valid), 1);
    endtask

    task automatic wait_rise();
        int   n = 0;
        logic prev = icache_read_enable;
        logic ok = 1'b0;
        while (!ok && n < 200) begin
            @(posedge clock);
            #3;
            n++;
            if (icache_read_enable && !prev) ok = 1'b1;
            prev = icache_read_enable;
        end
        check("rise_wait", 64'(ok), 1);
    endtask

    // Cache model: responds lat+1 cycles after a request, holds data until read_enable drops.
    initial begin
        int cnt = 0;
        icache_send_enable = 1'b0;
        icache_data        = '0;
        forever begin
            @(posedge clock);
            #2;
            if (reset) begin
                icache_send_enable = 1'b0;
                cnt = 0;
            end else if (!icache_send_enable) begin
                if (icache_read_enable) begin
                    if (cnt >= lat) begin
                        icache_send_enable = 1'b1;
                        icache_data        = insn_of(icache_address);
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end else if (!icache_read_enable) begin
                icache_send_enable = 1'b0;
            end
        end
    end

    // Decode is ready only while the scoreboard expects more instructions.
    initial begin
        decode_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            decode_ready = (sb.size() > 0);
        end
    end

    // Protocol watch: no new request while data is still presented; stable address.
    initial begin
        logic        prev_re = 1'b0;
        logic [63:0] prev_addr = '0;
        forever begin
            @(posedge clock);
            #1;
            if (icache_read_enable && !prev_re && icache_send_enable) viol++;
            if (icache_read_enable && prev_re && icache_address != prev_addr) viol++;
            prev_re   = icache_read_enable;
            prev_addr = icache_address;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (decode_valid && decode_ready && !redirect_valid) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 64'(sb.size()), 1);
                end else begin
                    mon_exp = sb.pop_front();
                    check("decode_pc", decode_pc, mon_exp);
                    check("decode_insn", 64'(decode_insn), 64'(insn_of(mon_exp)));
                end
                hs_cnt++;
            end
            if (decode_valid && !decode_ready) st_cnt++;
        end
    end

    initial begin
        int          reqs;
        int          unstable;
        logic [31:0] held;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("rst_read_enable", 64'(icache_read_enable), 0);
        check("rst_address", icache_address, 64'h1000);
        check("rst_decode_valid", 64'(decode_valid), 0);
        check("rst_decode_pc", decode_pc, 0);
        check("rst_decode_insn", 64'(decode_insn), 0);
        check_perf();
        sb.push_back(64'h1000);
        sb.push_back(64'h1004);
        sb.push_back(64'h1008);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #3;
        check("first_req", 64'(icache_read_enable), 1);
        check("first_addr", icache_address, 64'h1000);
        wait_drain();

        // Decode stall: slot holds 100c, no further request for 10 cycles.
        wait_valid();
        held = decode_insn;
        reqs = 0;
        unstable = 0;
        repeat (10) begin
            @(posedge clock);
            #3;
            if (icache_read_enable) reqs++;
            if (decode_insn != held) unstable++;
        end
        check("stall_reqs", 64'(reqs), 0);
        check("stall_insn_stable", 64'(unstable), 0);
        check("stall_pc", decode_pc, 64'h100c);
        check("stall_valid", 64'(decode_valid), 1);
        @(negedge clock);
        lat = 19;
        sb.push_back(64'h100c);
        @(posedge clock);
        @(posedge clock);
        #3;
        check("release_req", 64'(icache_read_enable), 1);
        check("release_addr", icache_address, 64'h1010);

        // Redirect in the middle of a long miss.
        repeat (4) @(posedge clock);
        #3;
        sb.push_back(64'h2000);
        do_redirect(64'h2002);
        check("miss_redir_valid", 64'(decode_valid), 0);
        check("miss_req_held", 64'(icache_read_enable), 1);
        check("miss_addr_held", icache_address, 64'h1010);
        wait_rise();
        check("redir_addr", icache_address, 64'h2000);
        wait_drain();
        lat = 0;

        // Redirect in the same cycle as the cache response.
        wait_valid();
        @(negedge clock);
        sb.push_back(64'h2004);
        sb.push_back(64'h3000);
        wait_rise();
        check("resp_redir_addr", icache_address, 64'h2008);
        do_redirect(64'h3000);
        check("resp_redir_valid", 64'(decode_valid), 0);
        wait_drain();

        // Redirect while the slot handshakes.
        wait_valid();
        @(negedge clock);
        sb.push_back(64'h4000);
        @(posedge clock);
        #3;
        do_redirect(64'h4000);
        check("hs_redir_valid", 64'(decode_valid), 0);
        wait_drain();
        @(posedge clock);
        #3;
        check_perf();

        // PC wrap at the top of the address space.
        wait_valid();
        @(negedge clock);
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        sb.push_back(64'h0);
        do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
        wait_drain();
        @(posedge clock);
        #3;
        check_perf();

        // Asynchronous reset in the middle of a miss.
        wait_valid();
        lat = 19;
        @(negedge clock);
        sb.push_back(64'h4);
        wait_drain();
        reqs = 0;
        while (!icache_read_enable && reqs < 50) begin
            @(posedge clock);
            #3;
            reqs++;
        end
        check("pre_reset_req", 64'(icache_read_enable), 1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("async_read_enable", 64'(icache_read_enable), 0);
        check("async_address", icache_address, 64'h1000);
        check("async_valid", 64'(decode_valid), 0);
        sb.delete();
        hs_cnt = 0;
        st_cnt = 0;
        @(posedge clock);
        #3;
        check("in_reset_valid", 64'(decode_valid), 0);
        check_perf();
        @(posedge clock);
        #2;
        reset = 1'b0;
        lat = 0;
        sb.push_back(64'h1000);
        wait_drain();
        check("protocol_viol", 64'(viol), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
